// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its datapath / memory port.
// The master side is the sequencer; the slave side is the datapath or the testbench.
interface multicycle_sequencer_if;
   logic [6:0]  opcode_i;
   logic        branch_taken_i;
   logic        mem_ready_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic        ir_we_o;
   logic        pc_we_o;
   logic [1:0]  pc_sel_o;
   logic        reg_we_o;
   logic [1:0]  alu_op_o;
   logic [2:0]  state_o;
   logic        trap_o;
   logic        trap_cause_o;
   logic        retire_o;
   logic [31:0] instret_o;

   modport master (
      input  opcode_i, branch_taken_i, mem_ready_i,
      output mem_req_o, mem_we_o, ir_we_o, pc_we_o, pc_sel_o, reg_we_o,
             alu_op_o, state_o, trap_o, trap_cause_o, retire_o, instret_o
   );

   modport slave (
      output opcode_i, branch_taken_i, mem_ready_i,
      input  mem_req_o, mem_we_o, ir_we_o, pc_we_o, pc_sel_o, reg_we_o,
             alu_op_o, state_o, trap_o, trap_cause_o, retire_o, instret_o
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP
// for illegal opcodes and memory timeouts, plus a retired-instruction counter.
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   multicycle_sequencer_if.master bus
);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

   logic [2:0]  state_r;
   logic [2:0]  state_nxt_s;
   logic [6:0]  opcode_r;
   logic [7:0]  wait_r;
   logic [7:0]  wait_nxt_s;
   logic        trap_cause_r;
   logic        trap_cause_nxt_s;
   logic [31:0] instret_r;
   logic        timeout_s;
   logic        mem_req_s;
   logic        mem_we_s;
   logic        ir_we_s;
   logic        pc_we_s;
   logic [1:0]  pc_sel_s;
   logic        reg_we_s;
   logic [1:0]  alu_op_s;
   logic        retire_s;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

   // A ready in the limit cycle still wins over the timeout
   assign timeout_s = (wait_r == TIMEOUT_LIMIT) && !bus.mem_ready_i;

   // Next state, trap cause and memory wait counter
   always_comb begin
      state_nxt_s      = state_r;
      trap_cause_nxt_s = trap_cause_r;
      case (state_r)
         ST_FETCH: begin
            if (bus.mem_ready_i) begin
               state_nxt_s = ST_DECODE;
            end else if (timeout_s) begin
               state_nxt_s      = ST_TRAP;
               trap_cause_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (is_legal(bus.opcode_i)) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s      = ST_TRAP;
               trap_cause_nxt_s = 1'b0;
            end
         end
         ST_EXEC: begin
            case (opcode_r)
               OP_LOAD, OP_STORE: state_nxt_s = ST_MEM;
               OP_BRANCH:         state_nxt_s = ST_FETCH;
               default:           state_nxt_s = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (bus.mem_ready_i) begin
               state_nxt_s = (opcode_r == OP_STORE) ? ST_FETCH : ST_WB;
            end else if (timeout_s) begin
               state_nxt_s      = ST_TRAP;
               trap_cause_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_MEM;
            end
         end
         ST_WB:   state_nxt_s = ST_FETCH;
         ST_TRAP: state_nxt_s = ST_TRAP;
         default: state_nxt_s = ST_TRAP;
      endcase

      if (state_nxt_s != state_r) begin
         wait_nxt_s = 8'd0;
      end else if (((state_r == ST_FETCH) || (state_r == ST_MEM)) && !bus.mem_ready_i) begin
         wait_nxt_s = wait_r + 8'd1;
      end else begin
         wait_nxt_s = 8'd0;
      end
   end

   // Per-state control strobes; reset forces them low so an access in flight is dropped
   always_comb begin
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      ir_we_s   = 1'b0;
      pc_we_s   = 1'b0;
      pc_sel_s  = 2'd0;
      reg_we_s  = 1'b0;
      alu_op_s  = 2'd0;
      retire_s  = 1'b0;
      if (rst_i) begin
         mem_req_s = 1'b0;
         retire_s  = 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               mem_req_s = 1'b1;
               ir_we_s   = bus.mem_ready_i;
            end
            ST_EXEC: begin
               case (opcode_r)
                  OP_RTYPE: alu_op_s = 2'd2;
                  OP_ITYPE: alu_op_s = 2'd3;
                  OP_BRANCH: begin
                     alu_op_s = 2'd1;
                     pc_we_s  = 1'b1;
                     retire_s = 1'b1;
                     pc_sel_s = bus.branch_taken_i ? 2'd1 : 2'd0;
                  end
                  default: alu_op_s = 2'd0;
               endcase
            end
            ST_MEM: begin
               mem_req_s = 1'b1;
               mem_we_s  = (opcode_r == OP_STORE);
               if (bus.mem_ready_i && (opcode_r == OP_STORE)) begin
                  pc_we_s  = 1'b1;
                  retire_s = 1'b1;
               end else begin
                  pc_we_s  = 1'b0;
                  retire_s = 1'b0;
               end
            end
            ST_WB: begin
               reg_we_s = 1'b1;
               pc_we_s  = 1'b1;
               retire_s = 1'b1;
               case (opcode_r)
                  OP_JAL:  pc_sel_s = 2'd1;
                  OP_JALR: pc_sel_s = 2'd2;
                  default: pc_sel_s = 2'd0;
               endcase
            end
            default: begin
               mem_req_s = 1'b0;
            end
         endcase
      end
   end

   // FSM state, captured opcode, wait counter, trap cause and retire count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= ST_FETCH;
         opcode_r     <= 7'd0;
         wait_r       <= 8'd0;
         trap_cause_r <= 1'b0;
         instret_r    <= 32'd0;
      end else begin
         state_r      <= state_nxt_s;
         wait_r       <= wait_nxt_s;
         trap_cause_r <= trap_cause_nxt_s;
         if (state_r == ST_DECODE) begin
            opcode_r <= bus.opcode_i;
         end
         if (retire_s) begin
            instret_r <= instret_r + 32'd1;
         end
      end
   end

   assign bus.mem_req_o    = mem_req_s;
   assign bus.mem_we_o     = mem_we_s;
   assign bus.ir_we_o      = ir_we_s;
   assign bus.pc_we_o      = pc_we_s;
   assign bus.pc_sel_o     = pc_sel_s;
   assign bus.reg_we_o     = reg_we_s;
   assign bus.alu_op_o     = alu_op_s;
   assign bus.retire_o     = retire_s;
   assign bus.state_o      = state_r;
   assign bus.trap_o       = (state_r == ST_TRAP);
   assign bus.trap_cause_o = trap_cause_r;
   assign bus.instret_o    = instret_r;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max wait cycles for mem_ready_i per memory access, range 1..255.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 opcode_i  input  7  instruction opcode field from the instruction register, valid from the cycle after ir_we_o.
REQ-005 branch_taken_i  input  1  branch comparison result from the datapath, sampled in EXEC.
REQ-006 mem_ready_i  input  1  memory completion for the current mem_req_o access.
REQ-007 mem_req_o  output  1  memory access request.
REQ-008 mem_we_o  output  1  request is a write (store); qualified by mem_req_o.
REQ-009 ir_we_o  output  1  instruction register load strobe.
REQ-010 pc_we_o  output  1  PC update strobe.
REQ-011 pc_sel_o  output  2  next-PC select: 0 = PC+4, 1 = PC+imm (taken branch/JAL), 2 = rs1+imm (JALR).
REQ-012 reg_we_o  output  1  register file write strobe.
REQ-013 alu_op_o  output  2  ALU operation class: 0 = add, 1 = compare, 2 = R-type funct, 3 = I-type funct.
REQ-014 state_o  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-015 trap_o  output  1  sticky fault indicator.
REQ-016 trap_cause_o  output  1  0 = illegal opcode, 1 = memory timeout; valid while trap_o=1.
REQ-017 retire_o  output  1  one-cycle pulse per retired instruction.
REQ-018 instret_o  output  32  retired-instruction count.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs not listed for a state SHALL be 0.
REQ-020 FETCH: mem_req_o=1, mem_we_o=0; hold until mem_ready_i=1; in that cycle ir_we_o=1 and next state is DECODE.
REQ-021 DECODE: capture opcode_i into an internal register used by all later states of the instruction; next state is EXEC for legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111), else TRAP with cause 0.
REQ-022 EXEC alu_op_o: R-type=2, I-type=3, branch=1, all others=0.
REQ-023 EXEC next state: load/store -> MEM; branch -> FETCH; all other legal opcodes -> WB.
REQ-024 EXEC for a branch: pc_we_o=1, retire_o=1, pc_sel_o=1 if branch_taken_i=1 else 0.
REQ-025 MEM: mem_req_o=1, mem_we_o=1 only for store; hold until mem_ready_i=1; then load -> WB; store -> FETCH with pc_we_o=1, pc_sel_o=0 and retire_o=1 in that cycle.
REQ-026 WB: reg_we_o=1, pc_we_o=1, retire_o=1, next state FETCH; pc_sel_o=1 for JAL, 2 for JALR, 0 otherwise.
REQ-027 Exactly one retire_o pulse and one pc_we_o pulse SHALL occur per legal instruction; instret_o increments by 1 on each retire_o and wraps 0xFFFFFFFF -> 0.
REQ-028 A wait counter SHALL count consecutive cycles in FETCH or MEM with mem_ready_i=0, clearing on state entry and on mem_ready_i=1.
REQ-029 When the wait counter reaches MEM_TIMEOUT with mem_ready_i still 0, the next state is TRAP with cause 1; mem_ready_i=1 in that same cycle takes priority and completes normally.
REQ-030 TRAP: trap_o=1, all strobes and mem_req_o=0; TRAP is exited only by reset.
REQ-031 mem_req_o and mem_we_o SHALL remain stable while a request is outstanding (no change until mem_ready_i=1 or timeout).

Reset
REQ-032 While rst_i=1: state FETCH, all outputs 0 (mem_req_o forced 0), instret_o=0, wait counter 0, trap_o=0, trap_cause_o=0, captured opcode 0.
REQ-033 First cycle after rst_i falls: state_o=0 and mem_req_o=1.
REQ-034 rst_i asserted mid-access SHALL abandon the access immediately without a retire_o or pc_we_o pulse.

Verification
REQ-035 R-type 0110011, mem_ready_i=1 on first FETCH cycle -> states 0,1,2,4,0; reg_we_o=1 only in WB; instret_o goes 0 -> 1.
REQ-036 Load 0000011, mem_ready_i delayed 3 cycles in MEM -> mem_req_o=1, mem_we_o=0 for 4 MEM cycles, then WB with reg_we_o=1; store 0100011 -> mem_we_o=1, no WB, retire_o in the MEM completion cycle.
REQ-037 Branch 1100011 with branch_taken_i=1 -> pc_sel_o=1, pc_we_o=1 in EXEC; with 0 -> pc_sel_o=0; reg_we_o never 1.
REQ-038 Opcode 1111111 -> TRAP after DECODE, trap_o=1, trap_cause_o=0, instret_o unchanged, holds until rst_i.
REQ-039 MEM_TIMEOUT=4, mem_ready_i held 0 in FETCH -> TRAP with trap_cause_o=1; repeat with mem_ready_i=1 in the limit cycle -> DECODE, no trap.
REQ-040 Preload instret_o to 0xFFFFFFFF through 2^32-1 retirements (or a force) then retire one more -> instret_o=0; rst_i pulsed during MEM -> all outputs 0 asynchronously, no retire_o.
